// File: rtl/user_event_queue.sv
// PS/2 Set-2 scancode decoder with per-key hold tracking, auto-repeat and a
// show-ahead event FIFO with overflow reporting.
module user_event_queue #(
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter logic [31:0] REPEAT_DELAY  = 32'd27_000_000,
  parameter logic [31:0] REPEAT_PERIOD = 32'd5_400_000,
  parameter logic [6:0]  REPEAT_MASK   = 7'b000_0111
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [7:0] ps2_key_data_i,
  input  logic       ps2_key_data_en_i,
  input  logic       user_event_rd_req_i,
  output logic [2:0] user_event_o,
  output logic       user_event_ready_o,
  output logic       overflow_o,
  output logic [6:0] held_keys_o
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = AW + 1;
  localparam longint unsigned RPT_MAX =
    (REPEAT_DELAY > REPEAT_PERIOD) ? 64'(REPEAT_DELAY) : 64'(REPEAT_PERIOD);
  localparam int unsigned CW = $clog2(RPT_MAX + 64'd1);
  // Loads are one less than the interval so the push lands exactly N edges later.
  localparam logic [CW-1:0] DLY_LOAD = CW'(REPEAT_DELAY - 32'd1);
  localparam logic [CW-1:0] PER_LOAD = CW'(REPEAT_PERIOD - 32'd1);

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} dec_state_e;

  dec_state_e       state_q, state_d;
  logic [6:0]       held_q, held_d;
  logic             rpt_active_q, rpt_active_d;
  logic [CW-1:0]    rpt_cnt_q, rpt_cnt_d;
  logic [2:0]       rpt_key_q, rpt_key_d;
  logic [2:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             ovf_q, ovf_d;

  logic       is_e0, is_f0, ext, brk;
  logic [2:0] key_code;
  logic [6:0] key_oh;
  logic       key_valid, make_evt, brk_evt, make_push, make_rpt;
  logic       rpt_req, rpt_kill, rpt_push;
  logic       push_vld, full, empty, pop, wr_en;
  logic [2:0] push_code;

  function automatic logic [2:0] lookup(input logic is_ext, input logic [7:0] b);
    logic [2:0] c;
    c = '0;
    if (is_ext) begin
      case (b)
        8'h6B:   c = 3'd1;
        8'h74:   c = 3'd2;
        8'h72:   c = 3'd3;
        8'h75:   c = 3'd4;
        default: c = '0;
      endcase
    end else begin
      case (b)
        8'h29:   c = 3'd5;
        8'h4D:   c = 3'd6;
        8'h76:   c = 3'd7;
        default: c = '0;
      endcase
    end
    return c;
  endfunction

  always_comb begin
    is_e0     = (ps2_key_data_i == 8'hE0);
    is_f0     = (ps2_key_data_i == 8'hF0);
    ext       = (state_q == S_EXT) || (state_q == S_EXT_BRK);
    brk       = (state_q == S_BRK) || (state_q == S_EXT_BRK);
    key_code  = lookup(ext, ps2_key_data_i);
    key_valid = ps2_key_data_en_i && !is_e0 && !is_f0 && (key_code != '0);
    key_oh    = key_valid ? (7'd1 << (key_code - 3'd1)) : '0;
    make_evt  = key_valid && !brk;
    brk_evt   = key_valid && brk;
    make_push = make_evt && ((held_q & key_oh) == '0);
    make_rpt  = make_evt && ((REPEAT_MASK & key_oh) != '0);

    state_d = state_q;
    if (ps2_key_data_en_i) begin
      if (is_e0)      state_d = S_EXT;
      else if (is_f0) state_d = ext ? S_EXT_BRK : S_BRK;
      else            state_d = S_IDLE;
    end

    held_d = held_q;
    if (make_evt) held_d = held_q | key_oh;
    if (brk_evt)  held_d = held_q & ~key_oh;
  end

  // A waiting repeat yields to a decoded make and to any event that retargets
  // or stops the timer in the same cycle; it then sits at zero until free.
  always_comb begin
    rpt_req  = rpt_active_q && (rpt_cnt_q == '0);
    rpt_kill = brk_evt && rpt_active_q && (key_code == rpt_key_q);
    rpt_push = rpt_req && !make_push && !make_rpt && !rpt_kill;

    rpt_active_d = rpt_active_q;
    rpt_cnt_d    = rpt_cnt_q;
    rpt_key_d    = rpt_key_q;
    if (make_rpt) begin
      rpt_active_d = 1'b1;
      rpt_key_d    = key_code;
      rpt_cnt_d    = DLY_LOAD;
    end else if (rpt_kill) begin
      rpt_active_d = 1'b0;
      rpt_cnt_d    = '0;
    end else if (rpt_push) begin
      rpt_cnt_d    = PER_LOAD;
    end else if (rpt_active_q && (rpt_cnt_q != '0)) begin
      rpt_cnt_d    = rpt_cnt_q - CW'(1);
    end
  end

  always_comb begin
    push_vld  = make_push || rpt_push;
    push_code = make_push ? key_code : rpt_key_q;
    full      = (occ_q == OCC_W'(FIFO_DEPTH));
    empty     = (occ_q == '0);
    pop       = user_event_rd_req_i && !empty;
    wr_en     = push_vld && (!full || pop);
    ovf_d     = push_vld && full && !pop;

    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    occ_d    = occ_q;
    if (wr_en && !pop)      occ_d = occ_q + OCC_W'(1);
    else if (!wr_en && pop) occ_d = occ_q - OCC_W'(1);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= S_IDLE;
      held_q       <= '0;
      rpt_active_q <= 1'b0;
      rpt_cnt_q    <= '0;
      rpt_key_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      ovf_q        <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      held_q       <= held_d;
      rpt_active_q <= rpt_active_d;
      rpt_cnt_q    <= rpt_cnt_d;
      rpt_key_q    <= rpt_key_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      ovf_q        <= ovf_d;
      if (wr_en) mem_q[wr_ptr_q] <= push_code;
    end
  end

  assign user_event_o       = empty ? '0 : mem_q[rd_ptr_q];
  assign user_event_ready_o = !empty;
  assign overflow_o         = ovf_q;
  assign held_keys_o        = held_q;

endmodule

// File: tb/tb_user_event_queue.sv
// Scoreboard bench for user_event_queue: stimulus pushes expected events,
// a negedge monitor pops and compares whenever the bench reads the FIFO head.
module tb_user_event_queue;

  typedef struct {
    logic [2:0] code;
    int         at_cyc;   // -1 when the write edge is not tracked
  } exp_t;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic [7:0] data = '0;
  logic       en = 1'b0;
  logic       rd_req = 1'b0;
  logic [2:0] ev;
  logic       ready, ovf;
  logic [6:0] held;

  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   ovf_cnt = 0;
  int   last_k = 0;
  int   k;

  user_event_queue #(
    .FIFO_DEPTH   (4),
    .REPEAT_DELAY (32'd8),
    .REPEAT_PERIOD(32'd4),
    .REPEAT_MASK  (7'b000_0111)
  ) dut (
    .clk                (clk),
    .nrst               (nrst),
    .ps2_key_data_i     (data),
    .ps2_key_data_en_i  (en),
    .user_event_rd_req_i(rd_req),
    .user_event_o       (ev),
    .user_event_ready_o (ready),
    .overflow_o         (ovf),
    .held_keys_o        (held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ovf) ovf_cnt++;
    if (nrst && rd_req && ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event: got code %0d at cycle %0d, expected none", ev, cyc);
      end else begin
        e = sb.pop_front();
        if (ev !== e.code || (e.at_cyc >= 0 && cyc != e.at_cyc)) begin
          n_err++;
          $display("FAIL event_pop: got code %0d at cycle %0d, expected code %0d at cycle %0d",
                   ev, cyc, e.code, e.at_cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // Entered and left at posedge+#1; one byte per clock.
  task automatic send(input logic [7:0] b);
    data = b;
    en   = 1'b1;
    @(posedge clk); #1;
    en     = 1'b0;
    last_k = cyc;
  endtask

  task automatic expect_ev(input logic [2:0] code, input int at);
    exp_t x;
    x.code   = code;
    x.at_cyc = at;
    sb.push_back(x);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain(input string name);
    int i = 0;
    while (sb.size() != 0 && i < 60) begin
      @(posedge clk); #1;
      i++;
    end
    chk(name, sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    nrst = 1'b1;
    idle(1);
    chk("rst_ready", ready, 0);
    chk("rst_event", ev, 0);
    chk("rst_overflow", ovf, 0);
    chk("rst_held", held, 0);

    // 1/2: LEFT make, repeats at +8/+12/+16, extended break stops them
    rd_req = 1'b1;
    send(8'hE0);
    send(8'h6B);
    k = last_k;
    expect_ev(3'd1, k);
    chk("t1_ready", ready, 1);
    chk("t1_event", ev, 1);
    chk("t1_held", held, 7'b000_0001);
    expect_ev(3'd1, k + 8);
    expect_ev(3'd1, k + 12);
    expect_ev(3'd1, k + 16);
    while (cyc < k + 16) begin @(posedge clk); #1; end
    send(8'hE0);
    send(8'hF0);
    send(8'h6B);
    chk("t2_held_clear", held, 0);
    idle(20);
    wait_drain("t2_drain");

    // 3: DROP resend is not re-pushed and never repeats
    send(8'h29);
    expect_ev(3'd5, last_k);
    send(8'h29);
    chk("t3_held", held, 7'b001_0000);
    send(8'hF0);
    send(8'h29);
    chk("t3_held_clear", held, 0);
    idle(20);
    wait_drain("t3_drain");

    // 4: fill, overflow on 5th push, ordered drain, pop while empty
    rd_req = 1'b0;
    send(8'h29);     expect_ev(3'd5, -1);
    send(8'h4D);     expect_ev(3'd6, -1);
    send(8'h76);     expect_ev(3'd7, -1);
    send(8'hE0);
    send(8'h75);     expect_ev(3'd4, -1);
    chk("t4_ovf_before", ovf, 0);
    send(8'hE0);
    send(8'h6B);
    chk("t4_ovf_pulse", ovf, 1);
    send(8'hE0);
    chk("t4_ovf_one_cycle", ovf, 0);
    send(8'hF0);
    send(8'h6B);
    chk("t4_held", held, 7'b111_1000);
    rd_req = 1'b1;
    idle(4);
    chk("t4_ready_after_4", ready, 0);
    idle(1);
    chk("t4_ready_extra_pop", ready, 0);
    chk("t4_event_extra_pop", ev, 0);
    chk("t4_sb_empty", sb.size(), 0);
    rd_req = 1'b0;
    send(8'hF0); send(8'h29);
    send(8'hF0); send(8'h4D);
    send(8'hF0); send(8'h76);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("t4_held_clear", held, 0);

    // 5: full FIFO, pop and push on the same edge
    send(8'h29);     expect_ev(3'd5, -1);
    send(8'h4D);     expect_ev(3'd6, -1);
    send(8'h76);     expect_ev(3'd7, -1);
    send(8'hE0);
    send(8'h75);     expect_ev(3'd4, -1);
    send(8'hE0);
    rd_req = 1'b1;
    send(8'h6B);     expect_ev(3'd1, -1);
    rd_req = 1'b0;
    chk("t5_no_ovf", ovf, 0);
    chk("t5_head", ev, 6);
    send(8'hE0); send(8'hF0); send(8'h6B);
    send(8'hF0); send(8'h29);
    send(8'hF0); send(8'h4D);
    send(8'hF0); send(8'h76);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("t5_held_clear", held, 0);
    chk("t5_still_full", ready, 1);
    rd_req = 1'b1;
    wait_drain("t5_drain");
    idle(1);
    chk("t5_ready_empty", ready, 0);
    chk("t45_ovf_total", ovf_cnt, 1);

    // 6: unmapped extended code, ESC, reset mid-sequence
    send(8'hE0);
    send(8'h6C);
    idle(1);
    chk("t6_unmapped", ready, 0);
    send(8'h76);
    expect_ev(3'd7, last_k);
    send(8'hF0);
    send(8'h76);
    wait_drain("t6_drain");
    rd_req = 1'b0;
    send(8'h29);
    send(8'hE0);
    nrst = 1'b0;
    #1;
    chk("t6_rst_ready", ready, 0);
    chk("t6_rst_event", ev, 0);
    chk("t6_rst_ovf", ovf, 0);
    chk("t6_rst_held", held, 0);
    @(posedge clk); #1;
    nrst = 1'b1;
    send(8'h6B);
    idle(1);
    chk("t6_nonext_ignored", ready, 0);
    chk("t6_nonext_held", held, 0);
    rd_req = 1'b1;
    send(8'h29);
    expect_ev(3'd5, last_k);
    wait_drain("t6_post_reset");
    send(8'hF0);
    send(8'h29);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
